// File: rtl/phase_sequencer_if.sv
// Button, halt and phase-strobe bundle for phase_sequencer.
// The slave side is the sequencer and the master side is the board/controller.
interface phase_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             exec;
  logic             step;
  logic             halt;
  logic             phase1;
  logic             phase2;
  logic             phase3;
  logic             phase4;
  logic             phase5;
  logic             phase6;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output exec,
    output step,
    output halt,
    input  phase1,
    input  phase2,
    input  phase3,
    input  phase4,
    input  phase5,
    input  phase6,
    input  running,
    input  halted,
    input  instr_cnt
  );

  modport slave (
    input  exec,
    input  step,
    input  halt,
    output phase1,
    output phase2,
    output phase3,
    output phase4,
    output phase5,
    output phase6,
    output running,
    output halted,
    output instr_cnt
  );
endinterface

// File: rtl/phase_sequencer.sv
// Six-phase instruction-cycle generator with run/step/halt control.
// Define PHASE_DEBOUNCE_EN to add a DB_CYCLES counter filter per button.
module phase_sequencer #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  phase_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP,
    HALTED
  } state_t;

  // bit 0 = exec, bit 1 = step
  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] lvl;
  logic [1:0] lvl_d;
  logic [1:0] pulse;
  logic       exec_p;
  logic       step_p;

  assign raw = {bus.step, bus.exec};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef PHASE_DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYCLES + 1);

  logic [DW-1:0] db_cnt [2];

  // Level flips only after DB_CYCLES disagreeing samples in a row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lvl       <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DB_CYCLES - 1)) begin
          lvl[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  logic unused_db;

  assign unused_db = ^DB_CYCLES;
  assign lvl       = sync2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lvl_d <= '0;
    end else begin
      lvl_d <= lvl;
    end
  end

  assign pulse  = lvl & ~lvl_d;
  assign exec_p = pulse[0];
  assign step_p = pulse[1];

  state_t           state;
  logic [5:0]       phase;
  logic             stop_req;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] instr_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      phase     <= '0;
      stop_req  <= 1'b0;
      running   <= 1'b0;
      halted    <= 1'b0;
      instr_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (exec_p) begin
            state   <= RUN;
            phase   <= 6'b000001;
            running <= 1'b1;
          end else if (step_p) begin
            state   <= STEP;
            phase   <= 6'b000001;
            running <= 1'b1;
          end
        end
        RUN, STEP: begin
          if (state == RUN && exec_p) begin
            stop_req <= 1'b1;
          end
          if (phase[5]) begin
            instr_cnt <= instr_cnt + 1'b1;
            stop_req  <= 1'b0;
            // halt outranks a pending stop
            if (bus.halt) begin
              state   <= HALTED;
              phase   <= '0;
              running <= 1'b0;
              halted  <= 1'b1;
            end else if (stop_req || exec_p || state == STEP) begin
              state   <= IDLE;
              phase   <= '0;
              running <= 1'b0;
            end else begin
              phase <= 6'b000001;
            end
          end else begin
            phase <= phase << 1;
          end
        end
        HALTED: begin
          if (exec_p) begin
            state  <= IDLE;
            halted <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.phase1    = phase[0];
  assign bus.phase2    = phase[1];
  assign bus.phase3    = phase[2];
  assign bus.phase4    = phase[3];
  assign bus.phase5    = phase[4];
  assign bus.phase6    = phase[5];
  assign bus.running   = running;
  assign bus.halted    = halted;
  assign bus.instr_cnt = instr_cnt;

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized bench for phase_sequencer against a behavioural model.
// Button timing is derived from raw-sample history, not register structure.
module tb_phase_sequencer;

  localparam int CW = 4;
  localparam int DB = 16;
`ifdef PHASE_DEBOUNCE_EN
  localparam int PL   = DB + 4;
  localparam int PMAX = DB + 12;
`else
  localparam int PL   = 2;
  localparam int PMAX = 6;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_HALT = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  phase_sequencer_if #(.CNT_W(CW)) bus ();

  phase_sequencer #(
    .DB_CYCLES (DB),
    .CNT_W     (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errs = 0;
  int checks = 0;

  int mode;
  int ph;
  int cnt;
  bit stop;
  bit hist [2][3];
  bit dl [2];
  bit dp [2];
  int run_len [2];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = M_IDLE;
    ph   = 0;
    cnt  = 0;
    stop = 0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) hist[i][k] = 0;
      dl[i]      = 0;
      dp[i]      = 0;
      run_len[i] = 0;
    end
  endtask

  // hist[i][k] holds the raw level seen k+1 edges ago
  task automatic button(input int i, input bit raw, output bit p);
`ifdef PHASE_DEBOUNCE_EN
    p     = dl[i] & ~dp[i];
    dp[i] = dl[i];
    if (hist[i][1] == dl[i]) begin
      run_len[i] = 0;
    end else begin
      run_len[i]++;
      if (run_len[i] == DB) begin
        dl[i]      = hist[i][1];
        run_len[i] = 0;
      end
    end
`else
    p = hist[i][1] & ~hist[i][2];
`endif
    hist[i][2] = hist[i][1];
    hist[i][1] = hist[i][0];
    hist[i][0] = raw;
  endtask

  task automatic model_edge(input bit ex, input bit st, input bit hl);
    bit ep;
    bit sp;
    button(0, ex, ep);
    button(1, st, sp);
    case (mode)
      M_IDLE: begin
        if (ep) begin
          mode = M_RUN;
          ph   = 1;
        end else if (sp) begin
          mode = M_STEP;
          ph   = 1;
        end
      end
      M_RUN, M_STEP: begin
        if (mode == M_RUN && ep) stop = 1;
        if (ph == 6) begin
          cnt = (cnt + 1) % (1 << CW);
          if (hl) begin
            mode = M_HALT;
            ph   = 0;
          end else if (stop || mode == M_STEP) begin
            mode = M_IDLE;
            ph   = 0;
          end else begin
            ph = 1;
          end
          stop = 0;
        end else begin
          ph++;
        end
      end
      default: begin
        if (ep) mode = M_IDLE;
      end
    endcase
  endtask

  task automatic check_outputs();
    logic [5:0] obs;
    logic [5:0] exp;
    obs = {bus.phase6, bus.phase5, bus.phase4,
           bus.phase3, bus.phase2, bus.phase1};
    exp = (ph == 0) ? 6'd0 : 6'(1 << (ph - 1));
    check("phase", 32'(obs), 32'(exp));
    check("running", 32'(bus.running),
          32'(mode == M_RUN || mode == M_STEP));
    check("halted", 32'(bus.halted), 32'(mode == M_HALT));
    check("instr_cnt", 32'(bus.instr_cnt), 32'(cnt));
  endtask

  task automatic tick(input bit ex, input bit st, input bit hl);
    bus.exec = ex;
    bus.step = st;
    bus.halt = hl;
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge(ex, st, hl);
    @(negedge clk);
    check_outputs();
  endtask

  // Outputs must clear without any clock edge.
  task automatic async_reset();
    #2 reset = 1'b0;
    model_reset();
    #1 check_outputs();
    tick(0, 0, 0);
    reset = 1'b1;
  endtask

  initial begin
    int ex_left;
    int st_left;
    bus.exec = 1'b0;
    bus.step = 1'b0;
    bus.halt = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b1;

    repeat (3) tick(1, 0, 0);
    repeat (14 + DB) tick(0, 0, 0);
    repeat (PL) tick(1, 0, 0);
    repeat (12) tick(0, 0, 0);

    repeat (PL) tick(0, 1, 0);
    repeat (2) tick(0, 0, 0);
    repeat (PL) tick(0, 1, 0);
    repeat (12) tick(0, 0, 0);

    repeat (PL) tick(1, 0, 0);
    repeat (10) tick(0, 0, 1);
    repeat (PL) tick(0, 1, 0);
    repeat (6) tick(0, 0, 0);
    repeat (PL) tick(1, 0, 0);
    repeat (6) tick(0, 0, 0);

    repeat (PL) tick(1, 0, 0);
    for (int i = 0; i < 40 + DB && !bus.phase4; i++) tick(0, 0, 0);
    check("phase4_seen", 32'(bus.phase4), 32'd1);
    async_reset();
    repeat (10) tick(0, 0, 0);

    ex_left = 0;
    st_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (ex_left > 0) ex_left--;
      else if ($urandom_range(0, 9) == 0) ex_left = $urandom_range(1, PMAX);
      if (st_left > 0) st_left--;
      else if ($urandom_range(0, 9) == 0) st_left = $urandom_range(1, PMAX);
      if ($urandom_range(0, 499) == 0) async_reset();
      else tick(ex_left > 0, st_left > 0, $urandom_range(0, 5) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Instruction-cycle phase generator that sits directly upstream of the PC, RAM, controller and datapath stages of the simple CPU. It conditions the raw `exec` and `step` push-button inputs and runs a four-state run/step/halt controller. It emits six mutually exclusive phase strobes, `phase1`..`phase6`, one instruction per six clocks. It also keeps a retired-instruction counter for display.

## Interface
Parameters:
- `DB_CYCLES`, 16: consecutive stable synchronized samples required before a debounced input changes level. Used only with `PHASE_DEBOUNCE_EN`.
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: single system clock; all flops on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `exec` in 1: raw run/stop button, active-high, asynchronous to `clk`.
- `step` in 1: raw single-step button, active-high, asynchronous to `clk`.
- `halt` in 1: halt-instruction decode from the controller; sampled only in the `phase6` cycle.
- `phase1`..`phase6` out 1 each: phase strobes; registered; at most one high.
- `running` out 1: high in RUN or STEP.
- `halted` out 1: high in HALTED.
- `instr_cnt` out `CNT_W`: retired-instruction count.

## Operation
- Input path, per button:
  - Two-flop synchronizer, then optional debouncer.
  - Then a rising-edge detector that produces a one-clock pulse: `exec_p` or `step_p`.
- States: IDLE, RUN, STEP, HALTED. Phase index is held in a one-hot register; all zero outside RUN and STEP.
- IDLE:
  - `exec_p` → RUN.
  - Else `step_p` → STEP.
  - If both pulses arrive in the same cycle, `exec_p` wins.
  - Entering RUN or STEP drives `phase1` on the next clock.
- RUN:
  - Phases advance 1→2→…→6→1, one per clock.
  - `exec_p` sets an internal stop request. The current instruction always completes.
  - `step_p` is ignored.
- STEP:
  - Runs exactly one instruction (phase1..phase6), then returns to IDLE.
  - `exec_p` and `step_p` are ignored.
- End of instruction (the cycle in which `phase6` is high), priority order:
  1. `halt`=1 → HALTED.
  2. Stop request set, or state is STEP → IDLE; stop request cleared.
  3. Otherwise → `phase1` again (RUN continues).
- HALTED:
  - All phases low.
  - `exec_p` → IDLE; `step_p` is ignored.
- `instr_cnt` increments by 1 at the end of every `phase6` cycle, including the one that enters HALTED. It wraps modulo 2^`CNT_W`. It is cleared only by reset.
- Reset (async, any time, including mid-instruction):
  - All phases 0, state IDLE, stop request 0.
  - `running` 0, `halted` 0, `instr_cnt` 0.
  - Synchronizer, debouncer and edge-detect flops all cleared to 0.
  - A button already held at reset release therefore produces one pulse once its synchronized level is seen high.

## Timing
- Without debounce:
  - `exec` rising before clock edge E0 → `exec_p` high in the cycle after E1.
  - `phase1` is high after E2, i.e. 3 edges of latency.
- With debounce: latency grows by `DB_CYCLES`.
- Phase strobes each last exactly one clock, back-to-back, with no gap between `phase6` and the next `phase1` in RUN.
- Stop or halt: `phase6` is the last strobe; `running` falls on the same edge that clears `phase6`.
- `halt` sampled outside `phase6` has no effect.

## Configuration
- `PHASE_DEBOUNCE_EN` defined:
  - Each synchronized button feeds a counter-based filter. The filtered level changes only after `DB_CYCLES` consecutive samples differ from the current filtered level.
  - Any agreeing sample resets the count.
- Not defined:
  - The synchronizer output feeds the edge detector directly.
  - `DB_CYCLES` is unused and no debounce logic is built.

## Test plan
- Reset released, `exec` pulsed high for 3 clocks (no debounce): `phase1` high at edge 3; strobes cycle 1..6 continuously; `instr_cnt` = 2 after 12 phase clocks.
- In RUN, `exec` pulsed during `phase3`: `phase4`..`phase6` complete, then all phases 0, `running`=0, `instr_cnt` +1.
- From IDLE, `step` pulsed: exactly one phase1..phase6 sequence, `instr_cnt`=1, return to IDLE; a second `step` pulse during that sequence adds nothing.
- In RUN, `halt`=1 during `phase6` and `exec_p` in the same cycle: state HALTED, `halted`=1. `step` is ignored. Next `exec` pulse → IDLE, `halted`=0, counter retained.
- `reset` asserted during `phase4`: all outputs 0 immediately, without waiting for a clock. After release, no phase until a new `exec` rising edge.
- `PHASE_DEBOUNCE_EN` defined, `DB_CYCLES`=16:
  - 10-cycle `exec` glitch → no phases.
  - 20-cycle press → `phase1` 19 edges after the rising edge.
